text_buffer_controller: RTL
===========================

// Module: text_buffer_controller
// PURPOSE
//  Single owner of the character buffer write port and of the scroll pointer first_char that the video generator reads.
//  Accepts terminal commands (put char, scroll up, clear screen, clear to end of line) over a valid/ready handshake.
//  Sequences the resulting buffer writes, including multi-cycle blank fills.
//  Buffer is circular: ROWS*COLS cells, logical row 0 at first_char.
// PARAMETERS
//  ROWS       24     visible text rows
//  COLS       80     text columns
//  ROW_BITS   5      width of row indices
//  COL_BITS   7      width of column indices
//  ADDR_BITS  11     width of buffer addresses, >= clog2(ROWS*COLS)
//  BLANK_CHAR 8'h20  code written by fill operations
// PORTS
//  clk         in  1          clock
//  reset       in  1          reset, synchronous, active-high
//  cmd_valid   in  1          command present
//  cmd_ready   out 1          controller idle, can accept
//  cmd_op      in  2          00 put char, 01 scroll up, 10 clear screen, 11 clear to EOL
//  cmd_x       in  COL_BITS   column (ops 00, 11)
//  cmd_y       in  ROW_BITS   row (ops 00, 11)
//  cmd_char    in  8          char code (op 00)
//  first_char  out ADDR_BITS  physical address of logical (0,0); to video generator
//  wr_en       out 1          buffer write strobe
//  wr_addr     out ADDR_BITS  buffer write address
//  wr_data     out 8          buffer write data
//  busy        out 1          operation in progress
// BEHAVIOUR
//  - BUF = ROWS*COLS.
//  - Physical address of (x,y): first_char + y*COLS + x, computed at ADDR_BITS+1 bits; subtract BUF if >= BUF.
//  - first_char is always a multiple of COLS, so a line never wraps mid-row.
//  - FSM states: IDLE, PUT, FILL.
//  - cmd_ready = (state==IDLE) && !reset; busy = (state!=IDLE).
//  - A command is accepted at the edge where cmd_valid && cmd_ready; the fields are latched at that edge.
//  - Outputs wr_en/wr_addr/wr_data are registered. The first write is visible in the cycle after the accept edge.
//  - op 00 PUT: one cycle with wr_en=1, addr=phys(x,y), data=cmd_char, then IDLE.
//  - op 01 SCROLL: FILL COLS cycles at phys(0..COLS-1, 0) with BLANK_CHAR.
//    - At the edge ending the last write, first_char += COLS; it becomes 0 if the result == BUF.
//  - op 10 CLEAR: FILL BUF cycles at addresses 0..BUF-1 with BLANK_CHAR.
//    - At the edge ending the last write, first_char <= 0.
//  - op 11 EOL: FILL COLS-x cycles at phys(x..COLS-1, y) with BLANK_CHAR.
//  - Out of range (x>=COLS or y>=ROWS) for ops 00/11: command accepted, busy for 1 cycle, wr_en stays 0, no state change.
//  - FILL uses a down-counter of ADDR_BITS+1 bits and an incrementing address. Exit is on counter==1 at the last write.
//  - first_char changes only at operation end, never in the middle of a fill.
//  - cmd_valid while busy is ignored and must be held by the requester.
//  - Reset values: first_char=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, cmd_ready=0 while reset asserted, state IDLE.
//  - Reset mid-operation aborts at once: wr_en=0 from the next cycle and first_char=0; cells already written stay written.
// TESTING
//  - reset; put x=5,y=2,char 8'h41 -> one wr_en pulse, addr 165, data 8'h41; cmd_ready low that cycle, high the next.
//  - scroll with first_char=0 -> 80 consecutive writes, addr 0..79, data 8'h20; then first_char=80, cmd_ready=1.
//  - 23 scrolls (first_char=1840), then put x=3,y=1 -> addr 3 (wrap).
//    - 24th scroll -> writes 1840..1919, first_char=0.
//  - clear screen -> 1920 writes, addr 0..1919; busy high 1920 cycles; first_char=0.
//  - EOL x=78,y=0 -> 2 writes, addr 78,79.
//    - EOL x=80 -> no writes, busy 1 cycle.
//    - put y=24 -> no write.
//  - reset asserted during clear at write 100 -> wr_en=0 next cycle, first_char=0; cmd_ready=1 after release.

Source files
------------

// File: rtl/text_buffer_controller.sv
// Text buffer controller: single writer of the circular character buffer and owner of the
// scroll pointer first_char. Accepts put-char / scroll-up / clear-screen / clear-to-EOL
// commands over valid/ready and sequences the resulting (possibly multi-cycle) buffer writes.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle and not in reset)
//   cmd_op                00 put, 01 scroll up, 10 clear screen, 11 clear to end of line
//   cmd_x, cmd_y          column / row for put and clear-to-EOL
//   cmd_char              character for put
//   first_char            physical address of logical (0,0), read by the video generator
//   wr_en/wr_addr/wr_data registered buffer write port
//   busy                  an operation is in progress
module text_buffer_controller #(
  parameter int unsigned ROWS       = 24,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned COL_BITS   = 7,
  parameter int unsigned ADDR_BITS  = 11,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [COL_BITS-1:0]  cmd_x,
  input  logic [ROW_BITS-1:0]  cmd_y,
  input  logic [7:0]           cmd_char,
  output logic [ADDR_BITS-1:0] first_char,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam int unsigned BufCells = ROWS * COLS;
  localparam logic [ADDR_BITS:0] BufW  = (ADDR_BITS + 1)'(BufCells);
  localparam logic [ADDR_BITS:0] ColsW = (ADDR_BITS + 1)'(COLS);

  typedef enum logic [1:0] {StIdle, StPut, StFill} state_e;

  state_e               state;
  logic [ADDR_BITS:0]   count;    // remaining writes in the current fill, including this one
  logic [1:0]           fill_op;

  logic                 in_range;
  logic [ADDR_BITS:0]   row_off;
  logic [ADDR_BITS:0]   xy_sum;
  logic [ADDR_BITS:0]   xy_wrap;
  logic [ADDR_BITS-1:0] xy_addr;
  logic [ADDR_BITS:0]   eol_len;
  logic [ADDR_BITS:0]   scroll_sum;
  logic [ADDR_BITS-1:0] scrolled;

  assign cmd_ready = (state == StIdle) && !reset;
  assign busy      = (state != StIdle);

  // Physical address of (cmd_x, cmd_y): one conditional subtract suffices since both
  // first_char and the logical offset are below BUF.
  always_comb begin
    in_range   = (cmd_x < COL_BITS'(COLS)) && (cmd_y < ROW_BITS'(ROWS));
    row_off    = (ADDR_BITS + 1)'(cmd_y) * ColsW;
    xy_sum     = {1'b0, first_char} + row_off + (ADDR_BITS + 1)'(cmd_x);
    xy_wrap    = (xy_sum >= BufW) ? (xy_sum - BufW) : xy_sum;
    xy_addr    = xy_wrap[ADDR_BITS-1:0];
    eol_len    = ColsW - (ADDR_BITS + 1)'(cmd_x);
    scroll_sum = {1'b0, first_char} + ColsW;
    scrolled   = (scroll_sum == BufW) ? '0 : scroll_sum[ADDR_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      first_char <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      count      <= '0;
      fill_op    <= 2'b00;
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            fill_op <= cmd_op;
            unique case (cmd_op)
              2'b00: begin
                // Out-of-range put still spends one busy cycle, without a write.
                state <= StPut;
                wr_en <= in_range;
                if (in_range) begin
                  wr_addr <= xy_addr;
                  wr_data <= cmd_char;
                end
              end
              2'b01: begin
                state   <= StFill;
                wr_en   <= 1'b1;
                wr_addr <= first_char;
                wr_data <= BLANK_CHAR;
                count   <= ColsW;
              end
              2'b10: begin
                state   <= StFill;
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= BLANK_CHAR;
                count   <= BufW;
              end
              2'b11: begin
                if (in_range) begin
                  state   <= StFill;
                  wr_en   <= 1'b1;
                  wr_addr <= xy_addr;
                  wr_data <= BLANK_CHAR;
                  count   <= eol_len;
                end else begin
                  state <= StPut;
                  wr_en <= 1'b0;
                end
              end
            endcase
          end
        end
        StPut: begin
          state <= StIdle;
          wr_en <= 1'b0;
        end
        StFill: begin
          if (count == (ADDR_BITS + 1)'(1)) begin
            state <= StIdle;
            wr_en <= 1'b0;
            // Scroll pointer moves only once the fill has fully completed.
            if (fill_op == 2'b01) begin
              first_char <= scrolled;
            end else if (fill_op == 2'b10) begin
              first_char <= '0;
            end
          end else begin
            count   <= count - (ADDR_BITS + 1)'(1);
            // Fills never cross the end of the buffer, so a plain increment is enough.
            wr_addr <= wr_addr + ADDR_BITS'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
